// File: rtl/past_value_tracker.sv
// past_value_tracker
// Synthesizable history buffer that provides $past-style delayed samples to
// the downstream property-check logic. Samples are taken only on gated clocks
// (sample_en=1), and the sample from 'lag' gated clocks ago is read back with
// zero latency. An optional registered compare flags mismatches against
// expect_data and keeps a saturating failure count.
module past_value_tracker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [WIDTH-1:0]           sample_data,
    input  logic                       clear,
    input  logic [$clog2(DEPTH+1)-1:0] lag,
    output logic [WIDTH-1:0]           past_data,
    output logic                       past_valid,
    output logic                       lag_err,
    output logic [$clog2(DEPTH+1)-1:0] hist_count,
    input  logic                       check_en,
    input  logic [WIDTH-1:0]           expect_data,
    output logic                       check_fail,
    output logic                       check_skip,
    output logic [CNT_W-1:0]           fail_count
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    // One extra bit so wptr + DEPTH - lag never wraps for legal lags.
    localparam int IW = LW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [LW-1:0]    count;
    logic [IW-1:0]    idx_sum;
    logic             mismatch;

    // History write path: clear wins over a simultaneous sample, memory is
    // left as-is on clear because count gates every read.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wptr  <= '0;
            count <= '0;
        end else if (sample_en) begin
            mem[wptr] <= sample_data;
            wptr      <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (count != LW'(DEPTH)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Read index (wptr - lag) mod DEPTH; only meaningful when past_valid.
    always_comb begin
        idx_sum = IW'(wptr) + IW'(DEPTH) - IW'(lag);
        if (idx_sum >= IW'(DEPTH)) begin
            idx_sum = idx_sum - IW'(DEPTH);
        end
    end

    // Zero-latency read; data is forced to zero whenever the lookback is not
    // backed by real history, so stale or reset contents never leak out.
    always_comb begin
        lag_err    = (lag == '0) || (lag > LW'(DEPTH));
        past_valid = !lag_err && (lag <= count);
        past_data  = past_valid ? mem[idx_sum[PW-1:0]] : '0;
        hist_count = count;
        mismatch   = past_valid && (past_data != expect_data);
    end

    // Registered checker: uses pre-edge history, pulses one cycle later.
    // fail_count survives clear on purpose; only reset zeroes it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            check_fail <= 1'b0;
            check_skip <= 1'b0;
            fail_count <= '0;
        end else begin
            check_fail <= check_en && mismatch;
            check_skip <= check_en && !past_valid;
            if (check_en && mismatch && (fail_count != '1)) begin
                fail_count <= fail_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_past_value_tracker.sv
// Scoreboard bench for past_value_tracker: the driver pushes the expected
// per-cycle outputs from a queue-based history model; a monitor pops and
// compares them independently. A few literal spot checks pin known values.
module tb_past_value_tracker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH+1);

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] sample_data = '0;
    logic             clear = 1'b0;
    logic [LW-1:0]    lag = '0;
    logic [WIDTH-1:0] past_data;
    logic             past_valid;
    logic             lag_err;
    logic [LW-1:0]    hist_count;
    logic             check_en = 1'b0;
    logic [WIDTH-1:0] expect_data = '0;
    logic             check_fail;
    logic             check_skip;
    logic [CNT_W-1:0] fail_count;

    past_value_tracker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .rst_n(rst_n), .sample_en(sample_en),
        .sample_data(sample_data), .clear(clear), .lag(lag),
        .past_data(past_data), .past_valid(past_valid), .lag_err(lag_err),
        .hist_count(hist_count), .check_en(check_en),
        .expect_data(expect_data), .check_fail(check_fail),
        .check_skip(check_skip), .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] pd;
        logic             pv;
        logic             le;
        logic [LW-1:0]    hc;
        logic             f;
        logic             s;
        logic [CNT_W-1:0] fc;
    } item_t;

    item_t            exp_q[$];
    logic [WIDTH-1:0] hist[$];   // hist[0] is the newest gated sample
    logic             pend_fail = 1'b0;
    logic             pend_skip = 1'b0;
    int               model_fc  = 0;
    int               n_checks  = 0;
    int               n_pass    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_valid(input int lg);
        return (lg >= 1) && (lg <= DEPTH) && (lg <= hist.size());
    endfunction

    function automatic logic [WIDTH-1:0] model_past(input int lg);
        return model_valid(lg) ? hist[lg-1] : '0;
    endfunction

    // One clock of stimulus; expectations for this cycle go to the queue.
    task automatic step(input bit en, input logic [WIDTH-1:0] d, input bit clr,
                        input int lg, input bit cen, input logic [WIDTH-1:0] ex);
        item_t it;
        @(negedge clock);
        rst_n = 1'b1; sample_en = en; sample_data = d; clear = clr;
        lag = LW'(lg); check_en = cen; expect_data = ex;
        if (pend_fail && model_fc < (1 << CNT_W) - 1) model_fc++;
        it.pd = model_past(lg);
        it.pv = model_valid(lg);
        it.le = (lg == 0) || (lg > DEPTH);
        it.hc = LW'(hist.size());
        it.f  = pend_fail;
        it.s  = pend_skip;
        it.fc = CNT_W'(model_fc);
        exp_q.push_back(it);
        pend_fail = cen && it.pv && (it.pd != ex);
        pend_skip = cen && !it.pv;
        if (clr) hist.delete();
        else if (en) begin
            hist.push_front(d);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
    endtask

    task automatic do_reset();
        item_t it;
        @(negedge clock);
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; check_en = 1'b0; lag = LW'(1);
        hist.delete();
        pend_fail = 1'b0; pend_skip = 1'b0; model_fc = 0;
        it.pd = '0; it.pv = 1'b0; it.le = 1'b0; it.hc = '0;
        it.f = 1'b0; it.s = 1'b0; it.fc = '0;
        exp_q.push_back(it);
    endtask

    // Monitor: compare every presented cycle against the scoreboard entry.
    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk("past_data",  32'(past_data),  32'(it.pd));
                chk("past_valid", 32'(past_valid), 32'(it.pv));
                chk("lag_err",    32'(lag_err),    32'(it.le));
                chk("hist_count", 32'(hist_count), 32'(it.hc));
                chk("check_fail", 32'(check_fail), 32'(it.f));
                chk("check_skip", 32'(check_skip), 32'(it.s));
                chk("fail_count", 32'(fail_count), 32'(it.fc));
            end
        end
    end

    initial begin
        int lg;
        logic [WIDTH-1:0] ex;
        do_reset();
        // Three samples, lookback within and beyond history.
        step(1, 8'h11, 0, 1, 0, 0);
        step(1, 8'h22, 0, 1, 0, 0);
        step(1, 8'h33, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t1_count", 32'(hist_count), 3);
        chk("t1_lag1",  32'(past_data), 32'h33);
        step(0, 8'h00, 0, 3, 0, 0); #3;
        chk("t1_lag3",  32'(past_data), 32'h11);
        step(0, 8'h00, 0, 4, 0, 0); #3;
        chk("t1_lag4_valid", 32'(past_valid), 0);
        // Saturation and wrap-around.
        do_reset();
        for (int i = 1; i <= 6; i++) step(1, WIDTH'(i), 0, 1, 0, 0);
        for (int l = 1; l <= 4; l++) begin
            step(0, 8'h00, 0, l, 0, 0); #3;
            chk("t2_wrap", 32'(past_data), 32'(7 - l));
        end
        chk("t2_count", 32'(hist_count), 4);
        // Gating honoured.
        step(1, 8'hA0, 0, 1, 0, 0);
        repeat (5) step(0, 8'hFF, 0, 1, 0, 0);
        step(1, 8'hB0, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t3_lag1", 32'(past_data), 32'hB0);
        step(0, 8'h00, 0, 2, 0, 0); #3;
        chk("t3_lag2", 32'(past_data), 32'hA0);
        // Illegal lags produce skips, never failures.
        step(0, 8'h00, 0, 0, 1, 8'h12); #3;
        chk("t4_lag0_err", 32'(lag_err), 1);
        step(0, 8'h00, 0, 5, 1, 8'h12); #3;
        chk("t4_lag5_err", 32'(lag_err), 1);
        chk("t4_skip0", 32'(check_skip), 1);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t4_skip5", 32'(check_skip), 1);
        chk("t4_fc", 32'(fail_count), 0);
        // Mismatch then match.
        step(1, 8'h33, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 1, 8'h34);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t5_fail", 32'(check_fail), 1);
        chk("t5_fc", 32'(fail_count), 1);
        step(0, 8'h00, 0, 1, 1, 8'h33);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t5_nofail", 32'(check_fail), 0);
        // Clear beats a simultaneous sample; reset wipes everything.
        step(1, 8'h77, 1, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t6_clear_count", 32'(hist_count), 0);
        chk("t6_clear_fc", 32'(fail_count), 1);
        step(1, 8'h55, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0); #3;
        chk("t6_after_clear", 32'(past_data), 32'h55);
        do_reset(); #3;
        chk("t6_rst_valid", 32'(past_valid), 0);
        chk("t6_rst_fc", 32'(fail_count), 0);
        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                lg = int'($urandom_range(7));
                ex = ($urandom_range(1) == 1) ? model_past(lg) : WIDTH'($urandom);
                if ($urandom_range(3) == 0) ex = model_past(lg) ^ WIDTH'(1 << $urandom_range(WIDTH-1));
                step($urandom_range(9) < 7, WIDTH'($urandom), $urandom_range(29) == 0,
                     lg, $urandom_range(1) == 1, ex);
            end
        end
        step(0, 8'h00, 0, 1, 0, 0);
        repeat (2) @(negedge clock);
        #4;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
